// File: rtl/core_wb_arbiter.sv
// Round-robin arbiter that shares the regfile write port among NREQ writeback requesters.
// Latency: grant and forward tap in the same cycle; the regfile write lands 1 cycle later.
// Backpressure: ready is the combinational grant. It is forced low by i_wb_hold or rst, and ungranted requesters hold.
module core_wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int NREQ        = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             i_req_valid,
  output logic [NREQ-1:0]             o_req_ready,
  input  logic [NREQ*RFIDX_WIDTH-1:0] i_req_rd_idx,
  input  logic [NREQ*XLEN-1:0]        i_req_data,
  input  logic                        i_wb_hold,
  output logic                        o_rf_wen,
  output logic [RFIDX_WIDTH-1:0]      o_rf_idx,
  output logic [XLEN-1:0]             o_rf_dat,
  output logic                        o_fwd_valid,
  output logic [RFIDX_WIDTH-1:0]      o_fwd_idx,
  output logic [CNT_WIDTH-1:0]        o_wb_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [RFIDX_WIDTH-1:0] idx;
    logic [XLEN-1:0]        dat;
  } wb_t;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_k;
  logic [NREQ-1:0]  grant;
  logic             found;
  logic             xfer;
  wb_t              sel;
  wb_t              wb_q;
  logic             wen_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Search from ptr upward first, then wrap to the requesters below ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && k >= int'(ptr) && i_req_valid[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && k < int'(ptr) && i_req_valid[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
    if (rst || i_wb_hold) grant = '0;
  end

  always_comb begin
    gnt_k = '0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        gnt_k   = PTR_W'(k);
        sel.idx = i_req_rd_idx[k*RFIDX_WIDTH +: RFIDX_WIDTH];
        sel.dat = i_req_data[k*XLEN +: XLEN];
      end
    end
  end

  assign xfer        = |grant;
  assign o_req_ready = grant;
  assign o_fwd_valid = xfer && (sel.idx != '0);
  assign o_fwd_idx   = sel.idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_k == PTR_W'(NREQ - 1)) ? '0 : gnt_k + PTR_W'(1);
    end
  end

  // x0 transfers complete the handshake but never raise the write enable or the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q <= 1'b0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wen_q <= o_fwd_valid;
      if (xfer) wb_q <= sel;
      if (o_fwd_valid) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_rf_wen = wen_q;
  assign o_rf_idx = wb_q.idx;
  assign o_rf_dat = wb_q.dat;
  assign o_wb_cnt = cnt_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Scoreboard bench for core_wb_arbiter: directed writeback scenarios plus a narrow-counter wrap instance.
module tb_core_wb_arbiter;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] dat;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  valid = '0;
  logic [4:0]  idx [3];
  logic [31:0] dat [3];
  logic        hold = 1'b0;
  logic [2:0]  ready;
  logic        rf_wen, fwd_valid;
  logic [4:0]  rf_idx, fwd_idx;
  logic [31:0] rf_dat;
  logic [15:0] wb_cnt;

  logic [2:0]  w_valid = '0;
  logic [2:0]  w_ready;
  logic        w_wen, w_fwd_valid;
  logic [4:0]  w_idx, w_fwd_idx;
  logic [31:0] w_dat;
  logic [3:0]  w_cnt;

  int checks = 0;
  int errors = 0;
  wb_exp_t sb[$];

  always #5 clk = ~clk;

  core_wb_arbiter dut (
    .clk(clk), .rst(rst), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_rd_idx({idx[2], idx[1], idx[0]}), .i_req_data({dat[2], dat[1], dat[0]}),
    .i_wb_hold(hold), .o_rf_wen(rf_wen), .o_rf_idx(rf_idx), .o_rf_dat(rf_dat),
    .o_fwd_valid(fwd_valid), .o_fwd_idx(fwd_idx), .o_wb_cnt(wb_cnt)
  );

  core_wb_arbiter #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .i_req_valid(w_valid), .o_req_ready(w_ready),
    .i_req_rd_idx({5'd0, 5'd0, 5'd3}), .i_req_data({32'd0, 32'd0, 32'h0000_0033}),
    .i_wb_hold(1'b0), .o_rf_wen(w_wen), .o_rf_idx(w_idx), .o_rf_dat(w_dat),
    .o_fwd_valid(w_fwd_valid), .o_fwd_idx(w_fwd_idx), .o_wb_cnt(w_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_wen) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        wb_exp_t e;
        e = sb.pop_front();
        chk("wb_write", 64'({rf_idx, rf_dat}), 64'({e.idx, e.dat}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      idx[k] = '0;
      dat[k] = '0;
    end

    // Reset with all valid: ready forced low, registers cleared.
    valid = 3'b111;
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'(3'b000));
    chk("rst_wen", 64'(rf_wen), 64'(0));
    chk("rst_cnt", 64'(wb_cnt), 64'(0));
    chk("rst_idx_dat", 64'({rf_idx, rf_dat}), 64'(0));
    valid = 3'b000;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_wen", 64'(rf_wen), 64'(0));
      chk("idle_ready", 64'(ready), 64'(3'b000));
      chk("idle_cnt", 64'(wb_cnt), 64'(0));
    end

    // Single requester 1.
    valid  = 3'b010;
    idx[1] = 5'd5;
    dat[1] = 32'hDEAD_BEEF;
    #1;
    chk("r1_ready", 64'(ready), 64'(3'b010));
    chk("r1_fwd", 64'({fwd_valid, fwd_idx}), 64'({1'b1, 5'd5}));
    sb.push_back('{idx: 5'd5, dat: 32'hDEAD_BEEF});
    tick();
    valid = 3'b000;
    chk("r1_wen", 64'(rf_wen), 64'(1));
    chk("r1_cnt", 64'(wb_cnt), 64'(1));
    // ptr should now be 2: all valid grants requester 2; drop valid before the edge.
    valid = 3'b111;
    #1;
    chk("r1_ptr2", 64'(ready), 64'(3'b100));
    valid = 3'b000;

    // Reset then all three valid for 6 cycles: rotation 0,1,2,0,1,2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] e;
      int ek;
      ek = i % 3;
      e  = 3'b001 << ek;
      for (int k = 0; k < 3; k++) begin
        idx[k] = 5'(10 + k);
        dat[k] = 32'h0000_1000 * i + k;
      end
      valid = 3'b111;
      if (i > 0) chk("rr_wen_run", 64'(rf_wen), 64'(1));
      chk("rr_cnt", 64'(wb_cnt), 64'(i));
      #1;
      chk("rr_ready", 64'(ready), 64'(e));
      sb.push_back('{idx: 5'(10 + ek), dat: 32'h0000_1000 * i + ek});
      tick();
    end
    valid = 3'b000;
    chk("rr_wen_last", 64'(rf_wen), 64'(1));
    chk("rr_cnt6", 64'(wb_cnt), 64'(6));
    tick();
    chk("rr_wen_off", 64'(rf_wen), 64'(0));

    // x0 write on requester 2 (ptr is 0, only req2 valid).
    valid  = 3'b100;
    idx[2] = 5'd0;
    dat[2] = 32'h1234_5678;
    #1;
    chk("x0_ready", 64'(ready), 64'(3'b100));
    chk("x0_fwd_valid", 64'(fwd_valid), 64'(0));
    tick();
    valid = 3'b000;
    chk("x0_wen", 64'(rf_wen), 64'(0));
    chk("x0_cnt", 64'(wb_cnt), 64'(6));

    // Move ptr to 1 via requester 0, then hold for two cycles with all valid.
    valid  = 3'b001;
    idx[0] = 5'd7;
    dat[0] = 32'h0000_0077;
    sb.push_back('{idx: 5'd7, dat: 32'h0000_0077});
    tick();
    idx[1] = 5'd21;
    dat[1] = 32'hCAFE_0001;
    idx[2] = 5'd22;
    valid  = 3'b111;
    hold   = 1'b1;
    #1;
    chk("hold_ready", 64'(ready), 64'(3'b000));
    chk("hold_fwd", 64'(fwd_valid), 64'(0));
    chk("hold_inflight_wen", 64'(rf_wen), 64'(1));
    tick();
    chk("hold_ready2", 64'(ready), 64'(3'b000));
    chk("hold_wen_off", 64'(rf_wen), 64'(0));
    tick();
    hold = 1'b0;
    #1;
    chk("hold_release_ready", 64'(ready), 64'(3'b010));
    sb.push_back('{idx: 5'd21, dat: 32'hCAFE_0001});
    tick();
    valid = 3'b000;
    chk("hold_release_wen", 64'(rf_wen), 64'(1));
    chk("hold_cnt", 64'(wb_cnt), 64'(8));

    // ptr is 2; grant req0 at edge N, reset at edge N+1.
    valid  = 3'b001;
    idx[0] = 5'd9;
    dat[0] = 32'h0000_0099;
    #1;
    chk("rstmid_ready", 64'(ready), 64'(3'b001));
    sb.push_back('{idx: 5'd9, dat: 32'h0000_0099});
    tick();
    valid = 3'b000;
    rst   = 1'b1;
    chk("rstmid_inflight", 64'(rf_wen), 64'(1));
    tick();
    rst = 1'b0;
    chk("rstmid_wen", 64'(rf_wen), 64'(0));
    chk("rstmid_cnt", 64'(wb_cnt), 64'(0));
    valid = 3'b111;
    #1;
    chk("rstmid_ptr0", 64'(ready), 64'(3'b001));
    valid = 3'b000;

    // 4-bit counter: 17 writes wrap to 1.
    w_valid = 3'b001;
    for (int i = 0; i < 17; i++) begin
      chk("wrap_cnt", 64'(w_cnt), 64'(i % 16));
      tick();
    end
    w_valid = 3'b000;
    chk("wrap_cnt17", 64'(w_cnt), 64'(1));

    tick();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
